// File: rtl/dram_read_engine_pkg.sv
// Shared constants and FSM encoding for the DRAM read engine.
package dram_rd_pkg;

  localparam int MEM_DW         = 128;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_BEAT = 4;
  localparam int BEAT_BYTES     = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Beats needed for a word count; the +3 is done in 33 bits so 0xFFFF_FFFF cannot wrap.
  function automatic logic [31:0] beats_for(input logic [31:0] num);
    return 32'(({1'b0, num} + 33'd3) >> 2);
  endfunction

  function automatic logic [2:0] last_words_for(input logic [1:0] num_lsb);
    return (num_lsb == 2'd0) ? 3'd4 : {1'b0, num_lsb};
  endfunction

endpackage

// File: rtl/dram_read_engine_if.sv
// Request, word-output and memory user-port signals of the DRAM read engine.
interface dram_read_engine_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DW     = 128
);

  logic                  kick;
  logic                  busy;
  logic [31:0]           read_num;
  logic [31:0]           read_addr;
  logic [31:0]           buf_dout;
  logic                  buf_we;
  logic                  mem_cmd_en;
  logic                  mem_cmd_rdy;
  logic [ADDR_WIDTH-1:0] mem_cmd_addr;
  logic                  mem_rd_valid;
  logic [MEM_DW-1:0]     mem_rd_data;
  logic                  align_err;

  // master: the engine itself; slave: the requester plus memory controller around it
  modport master (
    input  kick, read_num, read_addr, mem_cmd_rdy, mem_rd_valid, mem_rd_data,
    output busy, buf_dout, buf_we, mem_cmd_en, mem_cmd_addr, align_err
  );

  modport slave (
    output kick, read_num, read_addr, mem_cmd_rdy, mem_rd_valid, mem_rd_data,
    input  busy, buf_dout, buf_we, mem_cmd_en, mem_cmd_addr, align_err
  );

endinterface

// File: rtl/dram_read_engine_fifo.sv
// Single-clock show-ahead beat FIFO with occupancy count and async reset.
module sync_beat_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      if (do_wr && !do_rd)      count <= count + (AW+1)'(1);
      else if (do_rd && !do_wr) count <= count - (AW+1)'(1);
    end
  end

  // Credit accounting upstream must make this impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/dram_read_engine.sv
// Credit-limited DRAM read engine: one command per 128-bit beat, returned beats
// are buffered and serialised into 32-bit words.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | waiting for a kick with non-zero read_num
//  ST_ISSUE | issuing read commands while credit allows
//  ST_DRAIN | all commands sent, waiting for the last word to be written
//  ST_DONE  | one cycle with busy low before returning to idle
module dram_read_engine
  import dram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  dram_read_engine_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [31:0]           cmd_left;
  logic [31:0]           beats_left;
  logic [2:0]            last_words;
  logic [CNT_W-1:0]      outstanding;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic [MEM_DW-1:0]     fifo_dout;
  logic [MEM_DW-1:0]     hold_data;
  logic [1:0]            hold_idx;
  logic [1:0]            hold_left;
  logic                  buf_we;
  logic [WORD_W-1:0]     buf_dout;
  logic                  align_err;
  logic                  cmd_en;
  logic                  active;
  logic                  kick_ok;
  logic                  cmd_fire;
  logic                  push;
  logic                  pop;
  logic                  credit_ok;

  assign active    = (state == ST_ISSUE) || (state == ST_DRAIN);
  assign kick_ok   = (state == ST_IDLE) && bus.kick && (bus.read_num != 32'd0);
  assign cmd_fire  = cmd_en && bus.mem_cmd_rdy;
  // Beats arriving outside a transfer are stale and never reach the buffer.
  assign push      = bus.mem_rd_valid && active;
  assign credit_ok = ({1'b0, fifo_count} + {1'b0, outstanding}) < (CNT_W+1)'(FIFO_DEPTH);
  assign pop       = active && (hold_left == 2'd0) && !fifo_empty && (beats_left != 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_en    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (kick_ok) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_en = (cmd_left != 32'd0) && credit_ok;
        if (cmd_en && bus.mem_cmd_rdy && (cmd_left == 32'd1)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((beats_left == 32'd0) && (hold_left == 2'd0)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_addr   <= '0;
      cmd_left   <= '0;
      last_words <= 3'd0;
      align_err  <= 1'b0;
    end else if (kick_ok) begin
      cmd_addr   <= ADDR_WIDTH'({bus.read_addr[31:4], 4'h0});
      cmd_left   <= beats_for(bus.read_num);
      last_words <= last_words_for(bus.read_num[1:0]);
      align_err  <= (bus.read_addr[3:0] != 4'h0);
    end else if (cmd_fire) begin
      cmd_addr   <= cmd_addr + ADDR_WIDTH'(BEAT_BYTES);
      cmd_left   <= cmd_left - 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (cmd_fire && !push) begin
      outstanding <= outstanding + CNT_W'(1);
    end else if (push && !cmd_fire) begin
      outstanding <= outstanding - CNT_W'(1);
    end
  end

  sync_beat_fifo #(
    .WIDTH (MEM_DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (bus.mem_rd_data),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  // Word 0 goes straight from the FIFO head to the output register so a beat
  // costs exactly two cycles of latency; words 1..3 come from the hold register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats_left <= '0;
      hold_data  <= '0;
      hold_idx   <= 2'd0;
      hold_left  <= 2'd0;
      buf_we     <= 1'b0;
      buf_dout   <= '0;
    end else if (kick_ok) begin
      beats_left <= beats_for(bus.read_num);
      buf_we     <= 1'b0;
    end else if (hold_left != 2'd0) begin
      buf_we    <= 1'b1;
      buf_dout  <= hold_data[{hold_idx, 5'd0} +: WORD_W];
      hold_idx  <= hold_idx + 2'd1;
      hold_left <= hold_left - 2'd1;
    end else if (pop) begin
      buf_we     <= 1'b1;
      buf_dout   <= fifo_dout[WORD_W-1:0];
      hold_data  <= fifo_dout;
      hold_idx   <= 2'd1;
      hold_left  <= (beats_left == 32'd1) ? 2'(last_words - 3'd1) : 2'd3;
      beats_left <= beats_left - 32'd1;
    end else begin
      buf_we <= 1'b0;
    end
  end

  assign bus.busy         = active;
  assign bus.buf_we       = buf_we;
  assign bus.buf_dout     = buf_dout;
  assign bus.mem_cmd_en   = cmd_en;
  assign bus.mem_cmd_addr = cmd_addr;
  assign bus.align_err    = align_err;

endmodule

// File: tb/tb_dram_read_engine.sv
// Randomised scoreboard bench for dram_read_engine with a behavioural memory model.
module tb_dram_read_engine;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_read_engine_if #(.ADDR_WIDTH(32), .MEM_DW(128)) bus ();

  dram_read_engine #(.ADDR_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    int unsigned due;
    logic [31:0] addr;
  } ret_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cmd_q[$];
  ret_t        ret_q[$];
  int          lat      = 1;
  int          gap      = 0;
  int          rdy_pct  = 100;
  int          stall    = 0;
  int unsigned last_due = 0;
  int          fired    = 0;
  int          started  = 0;
  int          word_idx = 0;
  int          words_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents: every 32-bit word is a fixed hash of its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_quiet_outs(input string tag);
    check({tag, "_busy"},     32'(bus.busy),       32'd0);
    check({tag, "_buf_we"},   32'(bus.buf_we),     32'd0);
    check({tag, "_buf_dout"}, bus.buf_dout,        32'd0);
    check({tag, "_cmd_en"},   32'(bus.mem_cmd_en), 32'd0);
    check({tag, "_cmd_addr"}, bus.mem_cmd_addr,    32'd0);
    check({tag, "_align"},    32'(bus.align_err),  32'd0);
  endtask

  // Monitor: words first so a beat started this cycle frees its credit before the command check.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.buf_we) begin
        check("busy_during_word", 32'(bus.busy), 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_word: got 0x%08h expected no word", bus.buf_dout);
        end else begin
          check("word", bus.buf_dout, exp_q.pop_front());
          if (word_idx % 4 == 0) started++;
          word_idx++;
        end
        words_seen++;
      end
      if (bus.mem_cmd_en && bus.mem_cmd_rdy) begin
        fired++;
        if (cmd_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_cmd: got addr 0x%08h expected no command", bus.mem_cmd_addr);
        end else begin
          check("cmd_addr", bus.mem_cmd_addr, cmd_q.pop_front());
        end
        check("credit_limit", 32'(fired - started <= DEPTH), 32'd1);
      end
    end
  end

  // Memory controller model: in-order returns after lat cycles, at least gap cycles apart.
  initial begin : responder
    ret_t         r;
    int unsigned  d;
    logic [127:0] beat;
    bus.mem_cmd_rdy  = 1'b1;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_cmd_en && bus.mem_cmd_rdy) begin
        d = cyc + lat;
        if (d < last_due + gap) d = last_due + gap;
        if (d < last_due) d = last_due;
        last_due = d;
        r.due  = d;
        r.addr = bus.mem_cmd_addr;
        ret_q.push_back(r);
      end
      @(posedge clk);
      #1;
      if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
        r = ret_q.pop_front();
        for (int k = 0; k < 4; k++) beat[32*k +: 32] = mem_word(r.addr + 32'(4 * k));
        bus.mem_rd_valid = 1'b1;
        bus.mem_rd_data  = beat;
      end else begin
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = {4{$urandom}};
      end
      if (stall > 0) begin
        bus.mem_cmd_rdy = 1'b0;
        stall--;
      end else begin
        bus.mem_cmd_rdy = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // Called #1 after a rising edge with the engine idle.
  task automatic xfer_start(input logic [31:0] addr, input logic [31:0] num);
    logic [31:0] base;
    int          beats;
    base  = {addr[31:4], 4'h0};
    beats = int'((num + 32'd3) / 32'd4);
    fired    = 0;
    started  = 0;
    word_idx = 0;
    for (int i = 0; i < int'(num); i++) exp_q.push_back(mem_word(base + 32'(4 * i)));
    for (int b = 0; b < beats; b++) cmd_q.push_back(base + 32'(16 * b));
    bus.kick      = 1'b1;
    bus.read_addr = addr;
    bus.read_num  = num;
    @(posedge clk);
    #1;
    bus.kick      = 1'b0;
    bus.read_addr = $urandom;
    bus.read_num  = $urandom;
    check("busy_after_kick", 32'(bus.busy), 32'(num != 32'd0));
    if (num != 32'd0) check("align_err_on_kick", 32'(bus.align_err), 32'(addr[3:0] != 4'h0));
  endtask

  task automatic kick_while_busy(input logic [31:0] addr, input logic [31:0] num);
    bus.kick      = 1'b1;
    bus.read_addr = addr;
    bus.read_num  = num;
    @(posedge clk);
    #1;
    bus.kick = 1'b0;
    check("busy_kick_ignored", 32'(bus.busy), 32'd1);
  endtask

  task automatic xfer_wait(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_timeout"},   32'(n < 3000), 32'd1);
    check({name, "_busy_fell"}, 32'(bus.busy), 32'd0);
    check({name, "_cmds_left"}, 32'(cmd_q.size()), 32'd0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] a;
    ret_t        r;
    int          w0;
    int          n;
    bus.kick      = 1'b0;
    bus.read_addr = '0;
    bus.read_num  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet_outs("reset");
    rst = 1'b0;

    // Spurious beat while idle must be dropped
    r.due = cyc + 2; r.addr = 32'h0000_5550;
    last_due = r.due;
    ret_q.push_back(r);
    repeat (6) @(posedge clk);
    #1;
    check("spurious_idle_busy", 32'(bus.busy), 32'd0);

    // Basic eight-word read
    lat = 1;
    xfer_start(32'h0000_1000, 32'd8);
    xfer_wait("t1");

    // Partial final beat
    @(posedge clk); #1;
    xfer_start(32'h0000_3000, 32'd5);
    xfer_wait("t2");

    // Stalled controller and long latency exercise the credit limit
    @(posedge clk); #1;
    lat = 30; stall = 10;
    xfer_start(32'h0000_8000, 32'd64);
    xfer_wait("t3a");
    @(posedge clk); #1;
    rdy_pct = 80;
    xfer_start(32'h0001_0000, 32'd100);
    xfer_wait("t3b");
    rdy_pct = 100; lat = 1;

    // Zero-length kick and a kick while busy
    @(posedge clk); #1;
    xfer_start(32'h0000_4000, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("num0_no_cmd", 32'(bus.mem_cmd_en), 32'd0);
    check("num0_idle", 32'(bus.busy), 32'd0);
    xfer_start(32'h0000_5000, 32'd12);
    repeat (2) @(posedge clk);
    #1;
    kick_while_busy(32'h0000_9990, 32'd40);
    xfer_wait("t4");

    // Misaligned start address and its clearing
    @(posedge clk); #1;
    xfer_start(32'h0000_1004, 32'd8);
    xfer_wait("t5a");
    check("align_sticky", 32'(bus.align_err), 32'd1);
    @(posedge clk); #1;
    xfer_start(32'h0000_2000, 32'd4);
    xfer_wait("t5b");
    check("align_cleared", 32'(bus.align_err), 32'd0);

    // Reset in mid-transfer with a beat still in flight
    @(posedge clk); #1;
    lat = 4; gap = 8;
    w0 = words_seen;
    xfer_start(32'h0000_6000, 32'd8);
    n = 0;
    while (words_seen < w0 + 3 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reach_3_words", 32'(n < 500), 32'd1);
    rst = 1'b1;
    #1;
    check_quiet_outs("mid_reset");
    exp_q.delete();
    cmd_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    gap = 0;
    n = 0;
    while (ret_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("t6_late_beats_drained", 32'(ret_q.size()), 32'd0);
    check("t6_idle_after_reset", 32'(bus.busy), 32'd0);
    lat = 2;
    xfer_start(32'h0000_7000, 32'd8);
    xfer_wait("t6_after");

    // Randomised transfers
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      lat     = $urandom_range(1, 12);
      rdy_pct = $urandom_range(60, 100);
      a = $urandom & 32'h0FFF_FFF0;
      if ($urandom_range(3) == 0) a = a + 32'($urandom_range(1, 15));
      xfer_start(a, 32'($urandom_range(1, 48)));
      xfer_wait("rand");
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
